mxv_sequencer: RTL and testbench
================================

Name: mxv_sequencer

Overview:
- Upstream controller for the accumulate processor (A, B, enable, retro -> out) in the P03 matrix-vector datapath.
- On start, reads an NxN matrix and an N vector from two synchronous-read memories.
- Streams element pairs into the processor one per cycle.
- Captures each row's accumulated sum, clears the accumulator between rows, and reports one result per row plus a done pulse.

Parameters:
- DW, 8, data width of data_t (A, B, memory data, results); comes from the shared package.
- N_MAX, 8, maximum matrix dimension; power of two.
- IW, $clog2(N_MAX), index width for row and column.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- dim  in  IW+1  matrix dimension, latched at start
- mat_addr  out  2*IW  matrix address {row, col}, row-major with stride N_MAX
- vec_addr  out  IW  vector address = col
- mat_rdata  in  DW  matrix data, valid 1 cycle after mat_addr
- vec_rdata  in  DW  vector data, valid 1 cycle after vec_addr
- A  out  DW  to processor = mat_rdata
- B  out  DW  to processor = vec_rdata
- enable  out  1  to processor: accumulate A*B
- retro  out  1  to processor: clear accumulator
- mac_out  in  DW  processor accumulator output
- res_valid  out  1  one-cycle result strobe
- res_data  out  DW  row result
- res_idx  out  IW  row index of res_data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, active-low): state IDLE, counters 0, all outputs 0 (mat_addr, vec_addr, enable, retro, res_valid, res_data, res_idx, busy, done).
- Dimension handling:
  - dim latched at start.
  - dim > N_MAX saturates to N_MAX.
  - dim == 0 skips all memory reads.
- States:
  - IDLE: on start, assert retro for that cycle (flushes stale accumulator), set row=0, col=0, go RUN. If dim==0, go DONE instead.
  - RUN: drive mat_addr={row,col}, vec_addr=col. col increments each cycle. When col==dim-1, go DRAIN.
  - DRAIN: no address issued; last element pair is consumed this cycle.
  - WRITE: res_valid=1, res_data=mac_out, res_idx=row, retro=1, enable=0. If row==dim-1 go DONE; else row++, col=0, go RUN.
  - DONE: done=1 for one cycle, go IDLE.
- Enable and data path:
  - enable is a registered flag that is high exactly in the cycle after each issued address (RUN col>=1, and DRAIN).
  - A and B pass through combinationally from the read data.
- Never assert enable and retro in the same cycle.
- Timing, with cycle 0 = start accepted:
  - Row r is written at cycle (r+1)*(dim+2).
  - done occurs at cycle dim*(dim+2)+1.
- Arithmetic: products and sums wrap modulo 2^DW (processor behaviour). The sequencer passes mac_out through unmodified.
- start while busy: ignored, with no effect on counters or the latched dim.
- Reset mid-operation: immediate return to IDLE with outputs 0. No res_valid or done is emitted for the aborted job.
- res_data holds its last value between strobes.

Decomposition:
- Shared package mxv_pkg:
  - state enum {IDLE, RUN, DRAIN, WRITE, DONE}
  - N_MAX and IW constants
  - data_t remains in global_pkg.
- Sub-module mxv_counter: sync clear, increment enable, terminal-count flag against a runtime limit. Instantiated twice, for col and row.

Test Plan:
- dim=2, M=[[1,2],[3,4]], v=[5,6] -> res_valid at cycle 4 (res_idx 0, res_data 17) and cycle 8 (res_idx 1, res_data 39); done at cycle 9.
- dim=1, M=[7], v=[3] -> retro at cycle 0, enable only at cycle 2; res_data 21 at cycle 3; done at cycle 4.
- dim=0 -> done at cycle 1; no enable and no res_valid; busy high for exactly 1 cycle.
- dim=2, all elements 15 -> res_data (225+225) mod 256 = 194 for both rows (wrap).
- start pulsed at cycle 3 during the dim=2 job -> results and timing identical to the first case.
- rst low at cycle 5 of the dim=2 job -> all outputs 0 immediately. Then a fresh start with dim=1, M=[2], v=[2] gives res_data 4 at cycle 3, proving retro flushed the stale sum.

Source files
------------

// File: rtl/global_pkg.sv
// Shared datapath types for the P03 matrix-vector datapath.
package global_pkg;

    localparam int DW = 8;

    typedef logic [DW-1:0] data_t;

endpackage

// File: rtl/mxv_pkg.sv
// Constants, state encodings and helpers for the matrix-vector sequencer.
package mxv_pkg;

    localparam int N_MAX = 8;
    localparam int IW    = $clog2(N_MAX);

    // Largest dimension the sequencer will run, at the width of the dim port.
    localparam logic [IW:0] DIM_MAX = (IW+1)'(N_MAX);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_RUN   = 3'd1;
    localparam state_t ST_DRAIN = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Oversized requests are clamped rather than rejected.
    function automatic logic [IW:0] sat_dim(input logic [IW:0] d);
        return (d > DIM_MAX) ? DIM_MAX : d;
    endfunction

endpackage

// File: rtl/mxv_sequencer_if.sv
// Bus between the sequencer, the two operand memories, the accumulate
// processor and the job controller.
interface mxv_sequencer_if import global_pkg::*, mxv_pkg::*; ();

    logic              start;
    logic [IW:0]       dim;
    logic [2*IW-1:0]   mat_addr;
    logic [IW-1:0]     vec_addr;
    data_t             mat_rdata;
    data_t             vec_rdata;
    data_t             A;
    data_t             B;
    logic              enable;
    logic              retro;
    data_t             mac_out;
    logic              res_valid;
    data_t             res_data;
    logic [IW-1:0]     res_idx;
    logic              busy;
    logic              done;

    // Sequencer side.
    modport master (
        input  start, dim, mat_rdata, vec_rdata, mac_out,
        output mat_addr, vec_addr, A, B, enable, retro,
               res_valid, res_data, res_idx, busy, done
    );

    // Environment side: controller, memories and processor.
    modport slave (
        output start, dim, mat_rdata, vec_rdata, mac_out,
        input  mat_addr, vec_addr, A, B, enable, retro,
               res_valid, res_data, res_idx, busy, done
    );

endinterface

// File: rtl/mxv_counter.sv
// Index counter with synchronous clear, increment enable and a terminal-count
// flag against a runtime limit.
module mxv_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == limit);

endmodule

// File: rtl/mxv_sequencer.sv
// Matrix-vector sequencer: walks an NxN matrix row by row against an N
// vector, feeds element pairs to the accumulate processor and reports one
// accumulated result per row.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; start pulses retro to flush the accumulator
//   RUN   | issuing {row,col} / col read addresses, one per cycle
//   DRAIN | no address; the last pair of the row is being accumulated
//   WRITE | mac_out is the row sum: strobe it out and clear the accumulator
//   DONE  | one-cycle completion pulse
module mxv_sequencer import global_pkg::*, mxv_pkg::*; (
    input  logic           clk,
    input  logic           rst,
    mxv_sequencer_if.master bus
);

    state_t      state_q;
    state_t      state_d;
    logic [IW:0] dim_q;
    logic [IW:0] dim_d;
    logic        enable_q;
    logic        enable_d;
    data_t       res_data_q;
    data_t       res_data_d;

    logic          col_clr;
    logic          col_inc;
    logic          row_clr;
    logic          row_inc;
    logic [IW-1:0] col;
    logic [IW-1:0] row;
    logic          col_tc;
    logic          row_tc;
    logic [IW-1:0] last_idx;
    logic [IW:0]   dim_sat;
    logic          retro;

    // Both counters stop at dim-1; dim==0 never reaches RUN so the wrap is harmless.
    assign last_idx = IW'(dim_q - (IW+1)'(1));
    assign dim_sat  = sat_dim(bus.dim);

    mxv_counter #(.W(IW)) u_col (
        .clk   (clk),
        .rst   (rst),
        .clr   (col_clr),
        .inc   (col_inc),
        .limit (last_idx),
        .cnt   (col),
        .tc    (col_tc)
    );

    mxv_counter #(.W(IW)) u_row (
        .clk   (clk),
        .rst   (rst),
        .clr   (row_clr),
        .inc   (row_inc),
        .limit (last_idx),
        .cnt   (row),
        .tc    (row_tc)
    );

    // Next-state, dimension latch and counter control.
    always_comb begin
        state_d = state_q;
        dim_d   = dim_q;
        col_clr = 1'b0;
        col_inc = 1'b0;
        row_clr = 1'b0;
        row_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dim_d   = dim_sat;
                    col_clr = 1'b1;
                    row_clr = 1'b1;
                    state_d = (dim_sat == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (col_tc) begin
                    state_d = ST_DRAIN;
                end else begin
                    col_inc = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                col_clr = 1'b1;
                if (row_tc) begin
                    state_d = ST_DONE;
                end else begin
                    row_inc = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data lags the address by one cycle, so enable trails RUN by one.
    // The row result is kept so res_data holds between strobes.
    always_comb begin
        enable_d   = (state_q == ST_RUN);
        res_data_d = res_data_q;
        if (state_q == ST_WRITE) begin
            res_data_d = bus.mac_out;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            dim_q      <= '0;
            enable_q   <= 1'b0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            dim_q      <= dim_d;
            enable_q   <= enable_d;
            res_data_q <= res_data_d;
        end
    end

    // Flush on job start and after each row has been captured.
    assign retro = ((state_q == ST_IDLE) && bus.start) || (state_q == ST_WRITE);

    // Output decode.
    always_comb begin
        bus.mat_addr  = '0;
        bus.vec_addr  = '0;
        if (state_q == ST_RUN) begin
            bus.mat_addr = {row, col};
            bus.vec_addr = col;
        end
        bus.A         = bus.mat_rdata;
        bus.B         = bus.vec_rdata;
        bus.enable    = enable_q;
        bus.retro     = retro;
        bus.res_valid = (state_q == ST_WRITE);
        bus.res_data  = (state_q == ST_WRITE) ? bus.mac_out : res_data_q;
        bus.res_idx   = row;
        bus.busy      = (state_q != ST_IDLE);
        bus.done      = (state_q == ST_DONE);
    end

    // The processor must never be asked to accumulate and clear at once.
    a_no_en_retro: assert property (@(posedge clk) disable iff (!rst) !(enable_q && retro));

endmodule

// File: tb/tb_mxv_sequencer.sv
// Directed, table-driven bench for mxv_sequencer with memory and
// accumulate-processor models.
module tb_mxv_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mxv_sequencer_if bus ();

    mxv_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mat_mem [0:63];
    logic [7:0] vec_mem [0:7];
    logic [7:0] acc = 8'd0;

    // Synchronous-read operand memories.
    always @(posedge clk) begin
        bus.mat_rdata <= mat_mem[bus.mat_addr];
        bus.vec_rdata <= vec_mem[bus.vec_addr];
    end

    // Accumulate processor; deliberately not tied to rst so stale sums survive an abort.
    always @(posedge clk) begin
        if (bus.retro)       acc <= 8'd0;
        else if (bus.enable) acc <= acc + 8'(bus.A * bus.B);
    end
    assign bus.mac_out = acc;

    typedef struct packed {
        logic [3:0]      dim_in;
        logic [7:0]      fill;
        logic [3:0][7:0] m;
        logic [1:0][7:0] v;
        logic [7:0][7:0] exp_res;
        int              extra_start;
    } vec_t;

    vec_t tbl [8];

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] last_res = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " mat_addr"},  32'(bus.mat_addr),  0);
        chk({tag, " vec_addr"},  32'(bus.vec_addr),  0);
        chk({tag, " enable"},    32'(bus.enable),    0);
        chk({tag, " retro"},     32'(bus.retro),     0);
        chk({tag, " res_valid"}, 32'(bus.res_valid), 0);
        chk({tag, " res_data"},  32'(bus.res_data),  0);
        chk({tag, " res_idx"},   32'(bus.res_idx),   0);
        chk({tag, " busy"},      32'(bus.busy),      0);
        chk({tag, " done"},      32'(bus.done),      0);
    endtask

    task automatic load_mem(input vec_t t);
        for (int i = 0; i < 64; i++) mat_mem[i] = t.fill;
        for (int i = 0; i < 8; i++)  vec_mem[i] = t.fill;
        if (t.fill == 8'd0) begin
            mat_mem[0] = t.m[0];
            mat_mem[1] = t.m[1];
            mat_mem[8] = t.m[2];
            mat_mem[9] = t.m[3];
            vec_mem[0] = t.v[0];
            vec_mem[1] = t.v[1];
        end
    endtask

    // Runs one job from the start cycle through two idle cycles after done,
    // checking every output against the expected cycle-by-cycle schedule.
    task automatic run_job(input vec_t t, input int id);
        int d, done_c, r, p;
        bit in_job, e_run, e_en, e_retro, e_valid;
        string tag;
        d      = (t.dim_in > 4'd8) ? 8 : int'(t.dim_in);
        done_c = d * (d + 2) + 1;
        load_mem(t);
        for (int c = 0; c <= done_c + 2; c++) begin
            @(negedge clk);
            bus.start = (c == 0) || (c == t.extra_start);
            bus.dim   = (c == 0) ? t.dim_in : 4'd1;
            #1;
            in_job  = (c >= 1) && (c < done_c);
            r       = in_job ? (c - 1) / (d + 2) : 0;
            p       = in_job ? (c - 1) % (d + 2) : 0;
            e_run   = in_job && (p < d);
            e_en    = in_job && (p >= 1) && (p <= d);
            e_valid = in_job && (p == d + 1);
            e_retro = (c == 0) || e_valid;
            tag     = $sformatf("job%0d c%0d", id, c);
            chk({tag, " enable"},    32'(bus.enable),    32'(e_en));
            chk({tag, " retro"},     32'(bus.retro),     32'(e_retro));
            chk({tag, " res_valid"}, 32'(bus.res_valid), 32'(e_valid));
            chk({tag, " busy"},      32'(bus.busy),      32'((c >= 1) && (c <= done_c)));
            chk({tag, " done"},      32'(bus.done),      32'(c == done_c));
            if (e_run) begin
                chk({tag, " mat_addr"}, 32'(bus.mat_addr), 32'(r * 8 + p));
                chk({tag, " vec_addr"}, 32'(bus.vec_addr), 32'(p));
            end
            if (e_en) begin
                chk({tag, " A"}, 32'(bus.A), 32'(mat_mem[r * 8 + p - 1]));
                chk({tag, " B"}, 32'(bus.B), 32'(vec_mem[p - 1]));
            end
            if (e_valid) begin
                chk({tag, " res_data"}, 32'(bus.res_data), 32'(t.exp_res[r]));
                chk({tag, " res_idx"},  32'(bus.res_idx),  32'(r));
                last_res = t.exp_res[r];
            end else begin
                chk({tag, " res_data hold"}, 32'(bus.res_data), 32'(last_res));
            end
        end
        bus.start = 1'b0;
    endtask

    // Starts the 2x2 job, pulls rst low at abort_c, then runs a fresh 1x1 job.
    task automatic abort_job(input int abort_c);
        string tag;
        load_mem(tbl[0]);
        for (int c = 0; c < abort_c; c++) begin
            @(negedge clk);
            bus.start = (c == 0);
            bus.dim   = 4'd2;
        end
        @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b0;
        #1;
        tag = $sformatf("abort@%0d", abort_c);
        chk_zero(tag);
        last_res = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk({tag, " idle res_valid"}, 32'(bus.res_valid), 0);
            chk({tag, " idle done"},      32'(bus.done),      0);
            chk({tag, " idle busy"},      32'(bus.busy),      0);
        end
        run_job(tbl[7], 100 + abort_c);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.dim   = '0;
        for (int i = 0; i < 64; i++) mat_mem[i] = 8'd0;
        for (int i = 0; i < 8; i++)  vec_mem[i] = 8'd0;

        //          dim    fill   m (m3..m0)                   v (v1,v0)       expected row sums              extra start
        tbl[0] = '{4'd2, 8'd0,  {8'd4, 8'd3, 8'd2, 8'd1},   {8'd6, 8'd5},   {48'd0, 8'd39, 8'd17},        -1};
        tbl[1] = '{4'd1, 8'd0,  {8'd0, 8'd0, 8'd0, 8'd7},   {8'd0, 8'd3},   {56'd0, 8'd21},               -1};
        tbl[2] = '{4'd0, 8'd0,  {8'd0, 8'd0, 8'd0, 8'd0},   {8'd0, 8'd0},   64'd0,                        -1};
        tbl[3] = '{4'd2, 8'd0,  {8'd15, 8'd15, 8'd15, 8'd15}, {8'd15, 8'd15}, {48'd0, 8'd194, 8'd194},   -1};
        tbl[4] = '{4'd2, 8'd0,  {8'd4, 8'd3, 8'd2, 8'd1},   {8'd6, 8'd5},   {48'd0, 8'd39, 8'd17},         3};
        tbl[5] = '{4'd9, 8'd1,  32'd0,                      16'd0,          {8{8'd8}},                    -1};
        tbl[6] = '{4'd3, 8'd2,  32'd0,                      16'd0,          {40'd0, 8'd12, 8'd12, 8'd12}, -1};
        tbl[7] = '{4'd1, 8'd0,  {8'd0, 8'd0, 8'd0, 8'd2},   {8'd0, 8'd2},   {56'd0, 8'd4},                -1};

        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i], i);
        end

        abort_job(5);
        abort_job(7);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
